// File: rtl/fixed_divide_pkg.sv
// Shared widths, pipeline depth and the per-stage record of the pipelined signed fixed-point divider.
package fixed_divide_pkg;

    localparam int Q_BITS   = 10;
    localparam int D_WIDTH  = 32;
    localparam int ED_WIDTH = D_WIDTH + Q_BITS + 1;
    localparam int LAT      = ED_WIDTH + 2;

    typedef struct packed {
        logic [ED_WIDTH-1:0] rem;
        logic [ED_WIDTH-1:0] quo;
        logic [ED_WIDTH-1:0] dvs;
        logic                sign;
        logic                div0;
        logic                valid;
    } stage_t;

    // Sign-extend first so that 0x8000_0000 yields 2^31 rather than wrapping.
    function automatic logic [ED_WIDTH-1:0] magnitude(input logic [D_WIDTH-1:0] x);
        logic [ED_WIDTH-1:0] ext;
        ext = {{(ED_WIDTH-D_WIDTH){x[D_WIDTH-1]}}, x};
        return x[D_WIDTH-1] ? (~ext + 1'b1) : ext;
    endfunction

endpackage

// File: rtl/fixed_divide_stage.sv
// One restoring-division step: shift in the next dividend bit, trial subtract, keep if non-negative.
module fixed_divide_stage
    import fixed_divide_pkg::*;
(
    input  logic   clock,
    input  logic   reset,
    input  stage_t cur,
    output stage_t nxt
);

    logic [2*ED_WIDTH-1:0] shifted;
    logic [ED_WIDTH:0]     trial;
    logic [ED_WIDTH-1:0]   rem_n, quo_n;
    logic [ED_WIDTH-1:0]   rem_q, quo_q, dvs_q;
    logic                  sign_q, div0_q, valid_q;

    // quo holds the not-yet-consumed dividend bits in its MSBs and the quotient bits found so far in its LSBs.
    always_comb begin
        shifted = {cur.rem, cur.quo} << 1;
        trial   = {1'b0, shifted[2*ED_WIDTH-1:ED_WIDTH]} - {1'b0, cur.dvs};
        rem_n   = shifted[2*ED_WIDTH-1:ED_WIDTH];
        quo_n   = shifted[ED_WIDTH-1:0];
        if (!trial[ED_WIDTH]) begin
            rem_n    = trial[ED_WIDTH-1:0];
            quo_n[0] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) valid_q <= 1'b0;
        else        valid_q <= cur.valid;
    end

    always_ff @(posedge clock) begin
        rem_q  <= rem_n;
        quo_q  <= quo_n;
        dvs_q  <= cur.dvs;
        sign_q <= cur.sign;
        div0_q <= cur.div0;
    end

    always_comb begin
        nxt = '{rem: rem_q, quo: quo_q, dvs: dvs_q, sign: sign_q, div0: div0_q, valid: valid_q};
    end

endmodule

// File: rtl/fixed_divide.sv
// Fully pipelined signed fixed-point divider, one result per clock, fixed latency.
// Define FIXED_DIVIDE_SATURATE_EN to clamp overflow and divide-by-zero; otherwise results wrap and x/0 = 0.
module fixed_divide
    import fixed_divide_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic [D_WIDTH-1:0] dividend,
    input  logic [D_WIDTH-1:0] divisor,
    input  logic               valid_in,
    output logic [D_WIDTH-1:0] quotient,
    output logic               valid_out
);

    stage_t pipe [0:ED_WIDTH];

    logic [ED_WIDTH-1:0] s0_quo, s0_dvs;
    logic                s0_sign, s0_div0, s0_valid;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) s0_valid <= 1'b0;
        else        s0_valid <= valid_in;
    end

    always_ff @(posedge clock) begin
        s0_quo  <= magnitude(dividend) << Q_BITS;
        s0_dvs  <= magnitude(divisor);
        s0_sign <= dividend[D_WIDTH-1] ^ divisor[D_WIDTH-1];
        s0_div0 <= (divisor == '0);
    end

    assign pipe[0] = '{rem: '0, quo: s0_quo, dvs: s0_dvs, sign: s0_sign, div0: s0_div0, valid: s0_valid};

    genvar i;
    generate
        for (i = 0; i < ED_WIDTH; i++) begin : g_stage
            fixed_divide_stage u_stage (
                .clock (clock),
                .reset (reset),
                .cur   (pipe[i]),
                .nxt   (pipe[i+1])
            );
        end
    endgenerate

    logic [ED_WIDTH-1:0] q_mag, q_signed;
    logic [D_WIDTH-1:0]  result;
    logic                unused_bits;

    assign q_mag       = pipe[ED_WIDTH].quo;
    assign q_signed    = pipe[ED_WIDTH].sign ? (~q_mag + 1'b1) : q_mag;
    assign unused_bits = ^{pipe[ED_WIDTH].rem, pipe[ED_WIDTH].dvs, q_signed[ED_WIDTH-1:D_WIDTH]};

`ifdef FIXED_DIVIDE_SATURATE_EN
    localparam logic [ED_WIDTH-1:0] POS_LIMIT = {{(ED_WIDTH-D_WIDTH+1){1'b0}}, {(D_WIDTH-1){1'b1}}};
    localparam logic [ED_WIDTH-1:0] NEG_LIMIT = {{(ED_WIDTH-D_WIDTH){1'b0}}, 1'b1, {(D_WIDTH-1){1'b0}}};
    localparam logic [D_WIDTH-1:0]  SAT_MAX   = {1'b0, {(D_WIDTH-1){1'b1}}};
    localparam logic [D_WIDTH-1:0]  SAT_MIN   = {1'b1, {(D_WIDTH-1){1'b0}}};

    always_comb begin
        result = q_signed[D_WIDTH-1:0];
        if (pipe[ED_WIDTH].div0)
            result = pipe[ED_WIDTH].sign ? SAT_MIN : SAT_MAX;
        else if (!pipe[ED_WIDTH].sign && q_mag > POS_LIMIT)
            result = SAT_MAX;
        else if (pipe[ED_WIDTH].sign && q_mag > NEG_LIMIT)
            result = SAT_MIN;
    end
`else
    always_comb begin
        result = q_signed[D_WIDTH-1:0];
        if (pipe[ED_WIDTH].div0)
            result = '0;
    end
`endif

    // quotient only moves on valid results so bubbles leave the last answer visible.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_out <= 1'b0;
            quotient  <= '0;
        end else begin
            valid_out <= pipe[ED_WIDTH].valid;
            if (pipe[ED_WIDTH].valid)
                quotient <= result;
        end
    end

endmodule

// File: tb/tb_fixed_divide.sv
// Scoreboard bench for fixed_divide: directed corner cases, random traffic with bubbles, mid-flight reset.
module tb_fixed_divide;

    localparam int LAT = 45;
`ifdef FIXED_DIVIDE_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] dividend, divisor;
    logic        valid_in;
    logic [31:0] quotient;
    logic        valid_out;

    typedef struct {
        logic [31:0] q;
        int          stamp;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] last_q = '0;

    fixed_divide dut (
        .clock     (clock),
        .reset     (reset),
        .dividend  (dividend),
        .divisor   (divisor),
        .valid_in  (valid_in),
        .quotient  (quotient),
        .valid_out (valid_out)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Real-number semantics: (a * 2^10) / b with truncation toward zero, then clamp or wrap.
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        longint n, d, q;
        n = longint'($signed(a)) * 1024;
        d = longint'($signed(b));
        if (d == 0) return SAT ? (a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : 32'h0;
        q = n / d;
        if (SAT && q > 64'sd2147483647)  return 32'h7FFF_FFFF;
        if (SAT && q < -64'sd2147483648) return 32'h8000_0000;
        return q[31:0];
    endfunction

    // The sampling edge counts as clock 1 of the LAT clocks.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic v, input logic [31:0] exp);
        @(negedge clock);
        dividend = a;
        divisor  = b;
        valid_in = v;
        if (v) sb.push_back('{q: exp, stamp: cyc + 1});
    endtask

    task automatic send_ref(input logic [31:0] a, input logic [31:0] b);
        send(a, b, 1'b1, ref_div(a, b));
    endtask

    task automatic drain();
        int w;
        w = 0;
        @(negedge clock);
        valid_in = 1'b0;
        while (sb.size() != 0 && w < LAT + 20) begin
            @(posedge clock);
            w++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #2;
            if (!reset) begin
                last_q = '0;
            end else if (valid_out) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got quotient %h with valid_out=1, expected no output", quotient);
                end else begin
                    e = sb.pop_front();
                    check("quotient", quotient, e.q);
                    check("latency", 32'(cyc - e.stamp + 1), 32'(LAT));
                    last_q = e.q;
                end
            end else begin
                check("hold", quotient, last_q);
            end
        end
    end

    initial begin : stimulus
        logic [31:0] a, b;
        int          sent;
        reset    = 1'b0;
        valid_in = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clock);
        check("reset_valid_out", {31'b0, valid_out}, 32'h0);
        check("reset_quotient", quotient, 32'h0);
        reset = 1'b1;

        send(32'd194560,      32'd7168,      1'b1, 32'd27794);
        send(-32'sd194560,    32'd7168,      1'b1, 32'hFFFF_936E);
        send(32'd194560,      -32'sd7168,    1'b1, 32'hFFFF_936E);
        send(-32'sd194560,    -32'sd7168,    1'b1, 32'd27794);
        send(32'd1024,        32'd3072,      1'b1, 32'd341);
        send(32'h7FFF_FFFF,   32'd1,         1'b1, SAT ? 32'h7FFF_FFFF : 32'hFFFF_FC00);
        send(32'd10240,       32'd0,         1'b1, SAT ? 32'h7FFF_FFFF : 32'h0);
        send(-32'sd10240,     32'd0,         1'b1, SAT ? 32'h8000_0000 : 32'h0);
        send(32'd0,           32'd12345,     1'b1, 32'h0);
        send(32'h8000_0000,   32'd1,         1'b1, SAT ? 32'h8000_0000 : 32'h0);
        send(32'h8000_0000,   32'hFFFF_FC00, 1'b1, SAT ? 32'h7FFF_FFFF : 32'h8000_0000);
        send(32'd1024,        32'hFFFF_FFFF, 1'b1, 32'hFFF0_0000);
        send(32'd5,           32'd5,         1'b0, 32'h0);
        send(32'd3072,        32'd1024,      1'b1, 32'd3072);
        drain();

        sent = 0;
        while (sent < 64) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = $urandom_range(1, 4096);
                2: b = $urandom >> $urandom_range(0, 31);
                default: b = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom_range(1, 50) << 10);
            endcase
            if ($urandom_range(0, 1)) b = -b;
            if ($urandom_range(0, 3) == 0) a = a >>> $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) begin
                send(a, b, 1'b0, 32'h0);
            end else begin
                send_ref(a, b);
                sent++;
            end
        end
        drain();

        for (int k = 0; k < 10; k++) begin
            if (k == 5) begin
                @(negedge clock);
                reset    = 1'b0;
                valid_in = 1'b0;
                sb.delete();
                #1;
                check("midreset_valid_out", {31'b0, valid_out}, 32'h0);
                check("midreset_quotient", quotient, 32'h0);
                @(negedge clock);
                reset = 1'b1;
            end
            send_ref($urandom, $urandom_range(1, 100000));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
